// File: rtl/wb_switch_n.sv
// Wishbone B3 classic 1-to-NSLAVE interconnect with registered decode, an
// internal default slave, and a wait-cycle watchdog that captures the fault address.
module wb_switch_n #(
   parameter int                 NSLAVE   = 4,
   parameter int                 AW       = 32,
   parameter int                 DW       = 32,
   parameter logic [NSLAVE*AW-1:0] ADDR_VEC = '0,
   parameter logic [NSLAVE*AW-1:0] MASK_VEC = '0,
   parameter int                 TIMEOUT  = 255,
   parameter logic [DW-1:0]      DEF_DATA = 32'hAAAAAAAA,
   parameter bit                 DEF_ERR  = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [AW-1:0]        m_adr_i,
   input  logic [DW-1:0]        m_dat_i,
   output logic [DW-1:0]        m_dat_o,
   input  logic [DW/8-1:0]      m_sel_i,
   input  logic                 m_we_i,
   input  logic                 m_cyc_i,
   input  logic                 m_stb_i,
   output logic                 m_ack_o,
   output logic                 m_err_o,
   output logic [AW-1:0]        s_adr_o,
   output logic [DW-1:0]        s_dat_o,
   output logic [DW/8-1:0]      s_sel_o,
   output logic                 s_we_o,
   output logic [NSLAVE-1:0]    s_cyc_o,
   output logic [NSLAVE-1:0]    s_stb_o,
   input  logic [NSLAVE*DW-1:0] s_dat_i,
   input  logic [NSLAVE-1:0]    s_ack_i,
   input  logic [NSLAVE-1:0]    s_err_i,
   output logic                 timeout_o,
   output logic [AW-1:0]        fault_adr_o
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DEF} state_t;

   state_t            state_q, state_d;
   logic [NSLAVE-1:0] sel_q, sel_d, hit_oh;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [AW-1:0]     fault_q, fault_d;
   logic [DW-1:0]     slv_dat;
   logic              ack_sel, err_sel;

   assign s_adr_o     = m_adr_i;
   assign s_dat_o     = m_dat_i;
   assign s_sel_o     = m_sel_i;
   assign s_we_o      = m_we_i;
   assign fault_adr_o = fault_q;
   assign ack_sel     = |(s_ack_i & sel_q);
   assign err_sel     = |(s_err_i & sel_q);

   // Scan from the top index down so the lowest matching slave overwrites the rest.
   always_comb begin
      hit_oh = '0;
      for (int i = NSLAVE - 1; i >= 0; i--) begin
         if ((MASK_VEC[i*AW +: AW] != '0) &&
             ((m_adr_i & MASK_VEC[i*AW +: AW]) == (ADDR_VEC[i*AW +: AW] & MASK_VEC[i*AW +: AW]))) begin
            hit_oh    = '0;
            hit_oh[i] = 1'b1;
         end
      end
   end

   always_comb begin
      slv_dat = '0;
      for (int i = 0; i < NSLAVE; i++) begin
         if (sel_q[i]) slv_dat = slv_dat | s_dat_i[i*DW +: DW];
      end
   end

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      fault_d   = fault_q;
      s_cyc_o   = '0;
      s_stb_o   = '0;
      m_ack_o   = 1'b0;
      m_err_o   = 1'b0;
      m_dat_o   = '0;
      timeout_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (m_cyc_i && m_stb_i) begin
               sel_d   = hit_oh;
               cnt_d   = '0;
               state_d = (|hit_oh) ? ST_ACTIVE : ST_DEF;
            end
         end
         ST_ACTIVE: begin
            if (!m_cyc_i) begin
               state_d = ST_IDLE;
            end else begin
               s_cyc_o = sel_q;
               s_stb_o = sel_q & {NSLAVE{m_stb_i}};
               // Error beats ack; ack beats watchdog expiry.
               if (err_sel) begin
                  m_err_o = 1'b1;
                  fault_d = m_adr_i;
                  state_d = ST_IDLE;
               end else if (ack_sel) begin
                  m_ack_o = 1'b1;
                  m_dat_o = slv_dat;
                  state_d = ST_IDLE;
               end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT))) begin
                  m_err_o   = 1'b1;
                  timeout_o = 1'b1;
                  fault_d   = m_adr_i;
                  s_cyc_o   = '0;
                  s_stb_o   = '0;
                  state_d   = ST_IDLE;
               end else if (TIMEOUT != 0) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_DEF: begin
            if (m_cyc_i) begin
               if (DEF_ERR) begin
                  m_err_o = 1'b1;
                  fault_d = m_adr_i;
               end else begin
                  m_ack_o = 1'b1;
                  m_dat_o = DEF_DATA;
               end
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         cnt_q   <= '0;
         fault_q <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end
   end

endmodule

// File: tb/tb_wb_switch_n.sv
// Directed bench for wb_switch_n: three slaves, 8-cycle watchdog, and a second
// instance with an erroring default slave sharing the same stimulus.
module tb_wb_switch_n;

   localparam int NS = 3;
   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [AW-1:0]   m_adr_i;
   logic [DW-1:0]   m_dat_i;
   logic [3:0]      m_sel_i;
   logic            m_we_i, m_cyc_i, m_stb_i;
   logic [NS*DW-1:0] s_dat_i;
   logic [NS-1:0]   s_ack_i, s_err_i;

   logic [DW-1:0]   m_dat_o, m_dat_e;
   logic            m_ack_o, m_err_o, m_ack_e, m_err_e;
   logic [AW-1:0]   s_adr_o, s_adr_e;
   logic [DW-1:0]   s_dat_o, s_dat_e;
   logic [3:0]      s_sel_o, s_sel_e;
   logic            s_we_o, s_we_e;
   logic [NS-1:0]   s_cyc_o, s_stb_o, s_cyc_e, s_stb_e;
   logic            timeout_o, timeout_e;
   logic [AW-1:0]   fault_adr_o, fault_adr_e;

   localparam logic [NS*AW-1:0] ADDRS = {32'h00000000, 32'h01000000, 32'h03000000};
   localparam logic [NS*AW-1:0] MASKS = {32'h03E00000, 32'h03000000, 32'h03000000};

   wb_switch_n #(.NSLAVE(NS), .AW(AW), .DW(DW), .ADDR_VEC(ADDRS), .MASK_VEC(MASKS),
      .TIMEOUT(8), .DEF_DATA(32'hAAAAAAAA), .DEF_ERR(1'b0)) u_dut (
      .clk(clk), .rst(rst), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o),
      .m_sel_i(m_sel_i), .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
      .m_ack_o(m_ack_o), .m_err_o(m_err_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
      .s_sel_o(s_sel_o), .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
      .timeout_o(timeout_o), .fault_adr_o(fault_adr_o));

   wb_switch_n #(.NSLAVE(NS), .AW(AW), .DW(DW), .ADDR_VEC(ADDRS), .MASK_VEC(MASKS),
      .TIMEOUT(8), .DEF_DATA(32'hAAAAAAAA), .DEF_ERR(1'b1)) u_dut_e (
      .clk(clk), .rst(rst), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_e),
      .m_sel_i(m_sel_i), .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
      .m_ack_o(m_ack_e), .m_err_o(m_err_e), .s_adr_o(s_adr_e), .s_dat_o(s_dat_e),
      .s_sel_o(s_sel_e), .s_we_o(s_we_e), .s_cyc_o(s_cyc_e), .s_stb_o(s_stb_e),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
      .timeout_o(timeout_e), .fault_adr_o(fault_adr_e));

   always #5 clk = ~clk;

   int vec_cnt = 0;
   int err_cnt = 0;
   logic [DW-1:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Pops the next expected read word when the master sees an ack.
   task automatic chk_read(input string tag);
      logic [DW-1:0] e;
      chk({tag, "_ack"}, {31'd0, m_ack_o}, 32'd1);
      if (exp_q.size() == 0) begin
         vec_cnt++;
         err_cnt++;
         $error("FAIL %s_queue observed=empty expected=entry", tag);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_dat"}, m_dat_o, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic start(input logic [AW-1:0] adr, input logic we, input logic [3:0] sel,
                        input logic [DW-1:0] dat);
      m_adr_i = adr; m_we_i = we; m_sel_i = sel; m_dat_i = dat;
      m_cyc_i = 1'b1; m_stb_i = 1'b1;
   endtask

   task automatic finish_xfer();
      tick();
      m_cyc_i = 1'b0; m_stb_i = 1'b0; s_ack_i = '0; s_err_i = '0;
      settle();
   endtask

   initial begin
      rst = 1'b1;
      m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = 1'b0; m_cyc_i = 1'b0; m_stb_i = 1'b0;
      s_dat_i = '0; s_ack_i = '0; s_err_i = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cyc", {29'd0, s_cyc_o}, 32'd0);
      chk("rst_ack", {31'd0, m_ack_o}, 32'd0);
      chk("rst_fault", fault_adr_o, 32'd0);
      rst = 1'b0;
      tick();

      // Read from s0, ack two cycles after the slave strobe; a stray s1 ack is ignored.
      start(32'h03000010, 1'b0, 4'hF, 32'd0);
      settle();
      chk("t1_idle_stb", {29'd0, s_stb_o}, 32'd0);
      tick();
      chk("t1_stb", {29'd0, s_stb_o}, 32'b001);
      exp_q.push_back(32'h12345678);
      s_ack_i = 3'b010;
      settle();
      chk("t1_stray_ack", {31'd0, m_ack_o}, 32'd0);
      tick();
      s_ack_i = '0;
      settle();
      chk("t1_wait_stb", {29'd0, s_stb_o}, 32'b001);
      tick();
      s_ack_i = 3'b001;
      s_dat_i[0*DW +: DW] = 32'h12345678;
      s_dat_i[1*DW +: DW] = 32'hFFFF0000;
      settle();
      chk_read("t1");
      finish_xfer();
      chk("t1_done_cyc", {29'd0, s_cyc_o}, 32'd0);

      // Write to s2 with broadcast checks.
      start(32'h00100004, 1'b1, 4'b0011, 32'hCAFEF00D);
      tick();
      chk("t2_stb", {29'd0, s_stb_o}, 32'b100);
      chk("t2_dat", s_dat_o, 32'hCAFEF00D);
      chk("t2_sel", {28'd0, s_sel_o}, 32'b0011);
      chk("t2_we", {31'd0, s_we_o}, 32'd1);
      chk("t2_adr", s_adr_o, 32'h00100004);
      s_ack_i = 3'b100;
      settle();
      chk("t2_ack", {31'd0, m_ack_o}, 32'd1);
      finish_xfer();

      // Unmapped read goes to the default slave; both flavours observed together.
      start(32'h00400000, 1'b0, 4'hF, 32'd0);
      settle();
      chk("t3_idle_ack", {31'd0, m_ack_o}, 32'd0);
      tick();
      exp_q.push_back(32'hAAAAAAAA);
      chk_read("t3");
      chk("t3_cyc", {29'd0, s_cyc_o}, 32'd0);
      chk("t3e_err", {31'd0, m_err_e}, 32'd1);
      chk("t3e_ack", {31'd0, m_ack_e}, 32'd0);
      finish_xfer();
      chk("t3_after_ack", {31'd0, m_ack_o}, 32'd0);

      // s1 never answers: watchdog fires eight cycles after its strobe.
      start(32'h01000004, 1'b0, 4'hF, 32'd0);
      tick();
      chk("t4_stb", {29'd0, s_stb_o}, 32'b010);
      repeat (7) tick();
      chk("t4_pre_err", {31'd0, m_err_o}, 32'd0);
      chk("t4_pre_cyc", {29'd0, s_cyc_o}, 32'b010);
      tick();
      chk("t4_err", {31'd0, m_err_o}, 32'd1);
      chk("t4_timeout", {31'd0, timeout_o}, 32'd1);
      chk("t4_exp_cyc", {29'd0, s_cyc_o}, 32'd0);
      tick();
      chk("t4_fault", fault_adr_o, 32'h01000004);
      chk("t4_post_cyc", {29'd0, s_cyc_o}, 32'd0);
      chk("t4_post_to", {31'd0, timeout_o}, 32'd0);
      m_cyc_i = 1'b0; m_stb_i = 1'b0;
      tick();

      // Ack on the expiry cycle wins over the watchdog.
      start(32'h01000008, 1'b0, 4'hF, 32'd0);
      tick();
      repeat (8) tick();
      s_ack_i = 3'b010;
      s_dat_i[1*DW +: DW] = 32'h5A5A1234;
      exp_q.push_back(32'h5A5A1234);
      settle();
      chk_read("t4v");
      chk("t4v_err", {31'd0, m_err_o}, 32'd0);
      chk("t4v_timeout", {31'd0, timeout_o}, 32'd0);
      finish_xfer();
      chk("t4v_fault", fault_adr_o, 32'h01000004);

      // Simultaneous ack and err from s0: err wins, data stays zero.
      start(32'h03000020, 1'b0, 4'hF, 32'd0);
      tick();
      s_ack_i = 3'b001; s_err_i = 3'b001;
      settle();
      chk("t4e_err", {31'd0, m_err_o}, 32'd1);
      chk("t4e_ack", {31'd0, m_ack_o}, 32'd0);
      chk("t4e_dat", m_dat_o, 32'd0);
      finish_xfer();
      chk("t4e_fault", fault_adr_o, 32'h03000020);

      // Master abort two cycles into an s0 transfer.
      start(32'h03000030, 1'b0, 4'hF, 32'd0);
      tick();
      tick();
      m_cyc_i = 1'b0; m_stb_i = 1'b0; s_ack_i = 3'b001;
      settle();
      chk("t5_cyc", {29'd0, s_cyc_o}, 32'd0);
      chk("t5_ack", {31'd0, m_ack_o}, 32'd0);
      tick();
      s_ack_i = '0;
      start(32'h01000010, 1'b0, 4'hF, 32'd0);
      tick();
      chk("t5_s1_stb", {29'd0, s_stb_o}, 32'b010);
      s_ack_i = 3'b010;
      s_dat_i[1*DW +: DW] = 32'h0BADBEEF;
      exp_q.push_back(32'h0BADBEEF);
      settle();
      chk_read("t5");
      finish_xfer();

      // Asynchronous reset mid-ACTIVE.
      start(32'h03000040, 1'b0, 4'hF, 32'd0);
      tick();
      chk("t6_pre_cyc", {29'd0, s_cyc_o}, 32'b001);
      s_ack_i = 3'b001;
      settle();
      rst = 1'b1;
      settle();
      chk("t6_cyc", {29'd0, s_cyc_o}, 32'd0);
      chk("t6_stb", {29'd0, s_stb_o}, 32'd0);
      chk("t6_ack", {31'd0, m_ack_o}, 32'd0);
      chk("t6_dat", m_dat_o, 32'd0);
      chk("t6_fault", fault_adr_o, 32'd0);
      m_cyc_i = 1'b0; m_stb_i = 1'b0; s_ack_i = '0;
      settle();
      rst = 1'b0;
      tick();
      start(32'h00000100, 1'b0, 4'hF, 32'd0);
      tick();
      chk("t6_s2_stb", {29'd0, s_stb_o}, 32'b100);
      s_ack_i = 3'b100;
      s_dat_i[2*DW +: DW] = 32'h600DF00D;
      exp_q.push_back(32'h600DF00D);
      settle();
      chk_read("t6");
      finish_xfer();

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
